block_cipher_round_ctrl: RTL
============================

Name: block_cipher_round_ctrl

Overview:
- Round sequencer for the 8-bit block cipher datapath.
- Accepts one plaintext block per valid/ready handshake and iterates the external round function NUM_ROUNDS times, supplying the round state, round key and round index each cycle.
- Generates the round-key schedule and presents the ciphertext on a valid/ready output.
- Sits between the plaintext source and the cipher's round datapath; the top level instantiates it next to the round logic.

Parameters:
- DATA_W, 8, block and key width in bits.
- NUM_ROUNDS, 4, rounds per block; must be >= 1.
- IDX_W, max(1, $clog2(NUM_ROUNDS)), width of the round index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_in  in  DATA_W  master key.
- key_load  in  1  capture key_in.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  DATA_W  plaintext.
- rnd_data_o  out  DATA_W  state into the round function.
- rnd_key_o  out  DATA_W  round key into the round function.
- rnd_idx_o  out  IDX_W  current round number.
- rnd_en_o  out  1  round function active this cycle.
- rnd_data_i  in  DATA_W  combinational round-function result.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- out_data  out  DATA_W  ciphertext.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low. While rst=0, every register clears: state=IDLE, key_reg=0, data_reg=0, rk_reg=0, idx=0, out_data=0, out_valid=0. in_ready=0 during reset; it is 1 in IDLE after reset.
- Reset mid-block: the block is discarded with no output. The next accepted block starts clean.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - key_load=1 captures key_in into key_reg.
  - in_valid=1 accepts a block: data_reg<=in_data, rk_reg<=effective key, idx<=0, go to ROUND.
  - Effective key is key_in when key_load and in_valid are both high in the same cycle (new key wins); otherwise it is key_reg.
- ROUND:
  - in_ready=0, rnd_en_o=1.
  - rnd_data_o=data_reg, rnd_key_o=rk_reg, rnd_idx_o=idx.
  - Each cycle: data_reg<=rnd_data_i, rk_reg<=rotl1(rk_reg) ^ zero-extended(idx+1), idx<=idx+1.
  - When idx==NUM_ROUNDS-1: out_data<=rnd_data_i, out_valid<=1, go to DONE.
- DONE:
  - out_valid=1. out_data is held stable until out_ready=1; then out_valid<=0 and go to IDLE.
  - in_ready=0, so the next accept occurs at the earliest one cycle after the output handshake.
- key_load outside IDLE is ignored; the key is stable for the whole block.
- rnd_en_o=0 and rnd_idx_o=0 outside ROUND. rnd_data_o and rnd_key_o mirror their registers at all times.
- Latency: if the accept happens at rising edge k, out_valid is high from edge k+NUM_ROUNDS.
- Throughput: one block per NUM_ROUNDS+2 cycles with no output stall.
- Round-key schedule: rk0=key; rk_r = rotl1(rk_{r-1}) ^ r, where r is truncated to DATA_W.

Optional Feature:
- Macro: CIPHER_PERF_CNT_EN.
- Defined: adds output port blk_cnt [15:0]. It increments on every output handshake (out_valid & out_ready), saturates at 16'hFFFF, and clears on reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package block_cipher_pkg holds:
  - DATA_W default.
  - FSM state enum (IDLE/ROUND/DONE).
  - rotl1 function.
  - Counter width constant.
- One natural sub-module: block_cipher_key_sched. It holds rk_reg, does load/advance, and outputs the current round key. The FSM lives in the parent.

Test Plan:
Bench model of the round function: rnd_data_i = rnd_data_o ^ rnd_key_o. Defaults are NUM_ROUNDS=4.
- Reset, then key_load with key_in=8'h00, then in_data=8'hF1 accepted -> round keys 00,01,00,03; out_data=8'hF3 with out_valid 4 cycles after accept.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data=8'hF3 stay stable, in_ready=0. Release -> one handshake, then IDLE with in_ready=1.
- key_load with key_in=8'h5A in the same cycle as accepting in_data=8'h00 -> round keys 5A,B5,69,D1; out_data=8'h57 (new key used).
- key_load with key_in=8'hFF during ROUND -> ignored; current block output unchanged, and the next block still uses the old key.
- Drive rst=0 in round 2 -> out_valid=0 immediately, state=IDLE. The next block F1 with key 00 yields F3 and no stale output.
- With CIPHER_PERF_CNT_EN defined, 3 back-to-back blocks -> blk_cnt=3. Forcing blk_cnt to 16'hFFFF plus one handshake -> blk_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/block_cipher_pkg.sv
// block_cipher_pkg: shared width defaults, FSM state type and key-rotation helper for the round controller
package block_cipher_pkg;
  localparam int CIPHER_DATA_W = 8;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  // rotate-left-by-one of the low w bits of x (w <= 64); callers size-cast the result
  function automatic logic [63:0] rotl1(input logic [63:0] x, input int w);
    return ((x << 1) | (x >> (w - 1))) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/block_cipher_key_sched.sv
// block_cipher_key_sched: round-key register; loads the block key, then advances rk = rotl1(rk) ^ (idx+1)
// ports: clk, rst (async active-low), load/key (start of block), adv/idx (one round step), rk (current round key)
import block_cipher_pkg::*;
module block_cipher_key_sched #(
  parameter int DATA_W = CIPHER_DATA_W,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [DATA_W-1:0] key,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] rk
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) rk <= '0;
    else if (load) rk <= key;
    else if (adv) rk <= DATA_W'(rotl1(64'(rk), DATA_W)) ^ (DATA_W'(idx) + DATA_W'(1));
endmodule

// File: rtl/block_cipher_round_ctrl.sv
// block_cipher_round_ctrl: round sequencer; accepts a plaintext block, drives NUM_ROUNDS round-function steps, emits ciphertext
// ports: clk, rst (async active-low); key_in/key_load master key; in_valid/in_ready/in_data plaintext;
//        rnd_data_o/rnd_key_o/rnd_idx_o/rnd_en_o to the round function, rnd_data_i its result;
//        out_valid/out_ready/out_data ciphertext; blk_cnt (only with CIPHER_PERF_CNT_EN) saturating output-handshake count
import block_cipher_pkg::*;
module block_cipher_round_ctrl #(
  parameter int DATA_W = CIPHER_DATA_W,
  parameter int NUM_ROUNDS = 4,
  parameter int IDX_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key_in,
  input  logic              key_load,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] rnd_data_o,
  output logic [DATA_W-1:0] rnd_key_o,
  output logic [IDX_W-1:0]  rnd_idx_o,
  output logic              rnd_en_o,
  input  logic [DATA_W-1:0] rnd_data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef CIPHER_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  blk_cnt
`endif
);
  state_t state;
  logic [DATA_W-1:0] key_reg, data_reg;
  logic [IDX_W-1:0] idx;
  logic accept, last;
  // in_ready is a register so it stays low for the first cycle out of reset
  assign accept = (state == IDLE) && in_ready && in_valid;
  assign last = idx == IDX_W'(NUM_ROUNDS - 1);
  assign rnd_en_o = state == ROUND;
  assign rnd_idx_o = rnd_en_o ? idx : '0;
  assign rnd_data_o = data_reg;
  block_cipher_key_sched #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_key_sched (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .adv  (rnd_en_o),
    .key  (key_load ? key_in : key_reg),
    .idx  (idx),
    .rk   (rnd_key_o)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      key_reg <= '0;
      data_reg <= '0;
      idx <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else
      case (state)
        IDLE: begin
          in_ready <= !accept;
          if (key_load) key_reg <= key_in;
          if (accept) begin
            data_reg <= in_data;
            idx <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          data_reg <= rnd_data_i;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            out_data <= rnd_data_i;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
`ifdef CIPHER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) blk_cnt <= '0;
    else if (out_valid && out_ready && blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
`endif
endmodule
